// File: rtl/addr_trans_req_pkg.sv
// Shared MMU types for the requester-side translation engine: TLB search result,
// translation exception codes, DMW field offsets and requester FSM states.
package addr_trans_req_pkg;

    localparam int TLB_IDX_W = 4;

    localparam int DMW_PLV0_BIT = 0;
    localparam int DMW_PLV3_BIT = 3;
    localparam int DMW_MAT_LSB  = 4;
    localparam int DMW_PSEG_LSB = 25;
    localparam int DMW_VSEG_LSB = 29;

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_2M = 6'd21;

    typedef struct packed {
        logic                 found;
        logic [TLB_IDX_W-1:0] index;
        logic [19:0]          ppn;
        logic [5:0]           ps;
        logic [1:0]           plv;
        logic [1:0]           mat;
        logic                 d;
        logic                 v;
    } tlb_result_t;

    typedef enum logic [2:0] {
        EXC_NONE = 3'd0,
        EXC_TLBR = 3'd1,
        EXC_PIF  = 3'd2,
        EXC_PIL  = 3'd3,
        EXC_PIS  = 3'd4,
        EXC_PPI  = 3'd5,
        EXC_PME  = 3'd6
    } trans_exc_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESP   = 2'd3
    } trans_state_t;

    // A window is usable only from the PLV0 or PLV3 class the current mode maps to.
    function automatic logic dmw_plv_ok(input logic [31:0] dmw, input logic [1:0] plv);
        return (plv == 2'd3) ? dmw[DMW_PLV3_BIT] : dmw[DMW_PLV0_BIT];
    endfunction

endpackage

// File: rtl/addr_trans_req_if.sv
// Request/response valid-ready bundle between a pipeline client and the
// translation requester.
interface addr_trans_req_if;
    import addr_trans_req_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_va;
    logic        req_store;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_pa;
    logic [1:0]  rsp_mat;
    trans_exc_t  rsp_exc;

    modport master (
        output req_valid, req_va, req_store, rsp_ready,
        input  req_ready, rsp_valid, rsp_pa, rsp_mat, rsp_exc
    );

    modport slave (
        input  req_valid, req_va, req_store, rsp_ready,
        output req_ready, rsp_valid, rsp_pa, rsp_mat, rsp_exc
    );
endinterface

// File: rtl/addr_trans_req_dmw_match.sv
// Direct-mapped window check: segment compare plus privilege enable, and the
// physical address / MAT the window would produce.
module addr_trans_req_dmw_match
    import addr_trans_req_pkg::*;
(
    input  logic [31:0] dmw,
    input  logic [31:0] va,
    input  logic [1:0]  plv,
    output logic        hit,
    output logic [31:0] pa,
    output logic [1:0]  mat
);

    assign hit = (va[31:29] == dmw[DMW_VSEG_LSB +: 3]) && dmw_plv_ok(dmw, plv);
    assign pa  = {dmw[DMW_PSEG_LSB +: 3], va[28:0]};
    assign mat = dmw[DMW_MAT_LSB +: 2];

endmodule

// File: rtl/addr_trans_req.sv
// Requester-side translation engine driving one TLB search port.
// Optional macro TRANS_PERF_CNT_EN builds the lookup / wait-cycle counters.
module addr_trans_req
    import addr_trans_req_pkg::*;
#(
    parameter bit IS_FETCH = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    addr_trans_req_if.slave     bus,
    input  logic                csr_da,
    input  logic [1:0]          csr_plv,
    input  logic [1:0]          csr_datf,
    input  logic [1:0]          csr_datm,
    input  logic [9:0]          csr_asid,
    input  logic [31:0]         csr_dmw0,
    input  logic [31:0]         csr_dmw1,
    output logic [18:0]         s_vppn,
    output logic                s_va_bit12,
    output logic [9:0]          s_asid,
    input  tlb_result_t         s_result,
    input  logic                s_ok,
    output logic [31:0]         perf_lookups,
    output logic [31:0]         perf_wait_cycles
);

    trans_state_t state_r, state_nxt_s;
    logic [31:0]  va_r;
    logic [9:0]   asid_r;
    logic         store_r;
    logic [31:0]  pa_r, pa_nxt_s;
    logic [1:0]   mat_r, mat_nxt_s;
    trans_exc_t   exc_r, exc_nxt_s;
    logic         accept_s, va_ld_s, rsp_ld_s;
    logic         dmw0_hit_s, dmw1_hit_s;
    logic [31:0]  dmw0_pa_s, dmw1_pa_s, tlb_pa_s;
    logic [1:0]   dmw0_mat_s, dmw1_mat_s;
    trans_exc_t   tlb_exc_s;
    logic         res_unused_s;

    addr_trans_req_dmw_match u_dmw_match0 (
        .dmw (csr_dmw0), .va (bus.req_va), .plv (csr_plv),
        .hit (dmw0_hit_s), .pa (dmw0_pa_s), .mat (dmw0_mat_s)
    );

    addr_trans_req_dmw_match u_dmw_match1 (
        .dmw (csr_dmw1), .va (bus.req_va), .plv (csr_plv),
        .hit (dmw1_hit_s), .pa (dmw1_pa_s), .mat (dmw1_mat_s)
    );

    assign accept_s     = bus.req_valid && (state_r == ST_IDLE) && !flush;
    assign res_unused_s = ^s_result.index;

    // Page-frame assembly and exception ranking for the result on the search port.
    always_comb begin
        tlb_pa_s  = {s_result.ppn, va_r[11:0]};
        tlb_exc_s = EXC_NONE;
        case (s_result.ps)
            PS_2M:   tlb_pa_s = {s_result.ppn[19:9], va_r[20:0]};
            default: tlb_pa_s = {s_result.ppn, va_r[11:0]};
        endcase
        if (!s_result.found) begin
            tlb_exc_s = EXC_TLBR;
        end else if (!s_result.v) begin
            tlb_exc_s = IS_FETCH ? EXC_PIF : (store_r ? EXC_PIS : EXC_PIL);
        end else if (csr_plv > s_result.plv) begin
            tlb_exc_s = EXC_PPI;
        end else if (!IS_FETCH && store_r && !s_result.d) begin
            tlb_exc_s = EXC_PME;
        end else begin
            tlb_exc_s = EXC_NONE;
        end
    end

    // Next-state and response-load decisions.
    always_comb begin
        state_nxt_s = state_r;
        va_ld_s     = 1'b0;
        rsp_ld_s    = 1'b0;
        pa_nxt_s    = pa_r;
        mat_nxt_s   = mat_r;
        exc_nxt_s   = exc_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (csr_da) begin
                        rsp_ld_s    = 1'b1;
                        pa_nxt_s    = bus.req_va;
                        mat_nxt_s   = IS_FETCH ? csr_datf : csr_datm;
                        exc_nxt_s   = EXC_NONE;
                        state_nxt_s = ST_RESP;
                    end else if (dmw0_hit_s || dmw1_hit_s) begin
                        rsp_ld_s    = 1'b1;
                        pa_nxt_s    = dmw0_hit_s ? dmw0_pa_s : dmw1_pa_s;
                        mat_nxt_s   = dmw0_hit_s ? dmw0_mat_s : dmw1_mat_s;
                        exc_nxt_s   = EXC_NONE;
                        state_nxt_s = ST_RESP;
                    end else begin
                        va_ld_s     = 1'b1;
                        state_nxt_s = ST_LOOKUP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (s_ok && flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (s_ok) begin
                    rsp_ld_s    = 1'b1;
                    pa_nxt_s    = tlb_pa_s;
                    mat_nxt_s   = s_result.mat;
                    exc_nxt_s   = tlb_exc_s;
                    state_nxt_s = ST_RESP;
                end else if (flush) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_LOOKUP;
                end
            end
            // The search port must finish its walk before a new VA may appear.
            ST_DRAIN: begin
                if (s_ok) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_RESP: begin
                if (flush || bus.rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, search-key and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            va_r    <= 32'd0;
            asid_r  <= 10'd0;
            store_r <= 1'b0;
            pa_r    <= 32'd0;
            mat_r   <= 2'd0;
            exc_r   <= EXC_NONE;
        end else begin
            state_r <= state_nxt_s;
            if (va_ld_s) begin
                va_r    <= bus.req_va;
                asid_r  <= csr_asid;
                store_r <= bus.req_store;
            end
            if (rsp_ld_s) begin
                pa_r  <= pa_nxt_s;
                mat_r <= mat_nxt_s;
                exc_r <= exc_nxt_s;
            end
        end
    end

    assign s_vppn        = va_r[31:13];
    assign s_va_bit12    = va_r[12];
    assign s_asid        = asid_r;
    assign bus.req_ready = (state_r == ST_IDLE);
    assign bus.rsp_valid = (state_r == ST_RESP);
    assign bus.rsp_pa    = pa_r;
    assign bus.rsp_mat   = mat_r;
    assign bus.rsp_exc   = exc_r;

`ifdef TRANS_PERF_CNT_EN
    logic [31:0] lookups_r, waits_r;

    // Searches issued and cycles spent waiting on the search port.
    always_ff @(posedge clk) begin
        if (reset) begin
            lookups_r <= 32'd0;
            waits_r   <= 32'd0;
        end else begin
            if (va_ld_s) begin
                lookups_r <= lookups_r + 32'd1;
            end
            if (((state_r == ST_LOOKUP) || (state_r == ST_DRAIN)) && !s_ok) begin
                waits_r <= waits_r + 32'd1;
            end
        end
    end

    assign perf_lookups     = lookups_r;
    assign perf_wait_cycles = waits_r;
`else
    assign perf_lookups     = 32'd0;
    assign perf_wait_cycles = 32'd0;
`endif

endmodule
